uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 Parameter TIMEOUT_TICKS, default 200, max baud_tick count allowed between bytes within a frame (8-bit).
REQ-003 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 baud_tick  input  1  8x-oversampled baud strobe, one clk wide.
REQ-006 byte_valid  input  1  one-clk pulse, received byte available (from UART receiver byte_received).
REQ-007 byte_data  input  8  received byte, valid when byte_valid=1.
REQ-008 reg_we  output  1  one-clk register write strobe.
REQ-009 reg_addr  output  4  register write address, valid with reg_we.
REQ-010 reg_wdata  output  8  register write data, valid with reg_we.
REQ-011 frame_ok  output  1  one-clk pulse, frame accepted.
REQ-012 frame_err  output  1  one-clk pulse, frame rejected.
REQ-013 err_code  output  2  last error cause: 0 none, 1 checksum, 2 address, 3 timeout.
REQ-014 busy  output  1  high while any state other than HUNT.

Function
REQ-015 Frame SHALL be 4 bytes: SYNC_BYTE, ADDR, DATA, CHK, where CHK = SYNC_BYTE ^ ADDR ^ DATA.
REQ-016 States SHALL be HUNT, GET_ADDR, GET_DATA, GET_CHK; undefined encodings SHALL return to HUNT next clk.
REQ-017 HUNT: byte_valid with byte_data==SYNC_BYTE -> GET_ADDR; any other byte ignored with no error pulse.
REQ-018 GET_ADDR: byte_valid with byte_data[7:4]==0 -> store addr, GET_DATA; byte_data[7:4]!=0 -> frame_err, err_code=2, HUNT.
REQ-019 GET_DATA: byte_valid -> store data, GET_CHK; a SYNC_BYTE value here SHALL be treated as data (no resync).
REQ-020 GET_CHK: byte_valid with correct CHK -> reg_we=1, frame_ok=1, HUNT; incorrect -> frame_err=1, err_code=1, HUNT, no write.
REQ-021 reg_we/frame_ok/frame_err SHALL assert in the clk after the byte_valid that completes or rejects the frame (latency 1) and last exactly one clk.
REQ-022 reg_addr/reg_wdata SHALL hold last written values between strobes.
REQ-023 Timeout counter (8-bit) SHALL clear on entry to GET_ADDR and on every byte_valid, increment on baud_tick outside HUNT, saturate, never wrap.
REQ-024 Counter reaching TIMEOUT_TICKS outside HUNT -> frame_err=1, err_code=3, HUNT, partial frame discarded.
REQ-025 byte_valid and timeout expiry in the same clk: byte SHALL win, counter cleared, no timeout.
REQ-026 err_code SHALL update only on a frame_err pulse and is not cleared by frame_ok.
REQ-027 byte_valid and baud_tick coincident: both SHALL be processed, counter cleared (byte takes priority over increment).
REQ-028 Back-to-back frames with zero gap SHALL all be accepted; byte_valid spacing of 1 clk SHALL be supported.

Reset
REQ-029 On rst_n=0: state HUNT, counter 0, reg_we=0, reg_addr=0, reg_wdata=0, frame_ok=0, frame_err=0, err_code=0, busy=0, immediately without clk.
REQ-030 Reset asserted mid-frame SHALL discard the frame with no write and no error pulse after release.

Verification
REQ-031 Bytes A5,03,5C,FA -> one clk after last byte: reg_we=1, reg_addr=3, reg_wdata=5C, frame_ok=1.
REQ-032 Bytes A5,03,5C,00 -> frame_err=1, err_code=1, reg_we never asserts.
REQ-033 Bytes 11,22,A5,1F -> first two ignored silently; frame_err=1, err_code=2 after 1F.
REQ-034 A5,03 then 200 baud_ticks without bytes -> frame_err=1, err_code=3, busy=0; next A5,03,5C,FA accepted.
REQ-035 A5,01,A5,01 (DATA=A5, CHK=A5^01^A5=01) -> reg_we=1, reg_addr=1, reg_wdata=A5.
REQ-036 rst_n pulsed low after A5,03 -> busy=0 at once; subsequent 5C,FA ignored, no strobes.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser: SYNC, ADDR, DATA, CHK frames become single register writes.
// Frames are dropped on a bad address, a bad checksum, or an inter-byte gap that runs too long.
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter logic [7:0] TIMEOUT_TICKS = 8'd200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       reg_we,
  output logic [3:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    GET_ADDR = 2'd1,
    GET_DATA = 2'd2,
    GET_CHK  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_ADDR = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  state_t     state;
  logic [7:0] tmo_cnt;
  logic [3:0] addr_q;
  logic [7:0] data_q;
  logic       tmo_hit;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] frame_chk(input logic [3:0] a, input logic [7:0] d);
    return SYNC_BYTE ^ {4'h0, a} ^ d;
  endfunction

  assign tmo_hit = (state != HUNT) && (tmo_cnt >= TIMEOUT_TICKS);
  assign busy    = (state != HUNT);

  // A received byte always outranks both timeout expiry and the tick increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      tmo_cnt   <= 8'd0;
      addr_q    <= 4'd0;
      data_q    <= 8'd0;
      reg_we    <= 1'b0;
      reg_addr  <= 4'd0;
      reg_wdata <= 8'd0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      reg_we    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (byte_valid) begin
        tmo_cnt <= 8'd0;
        case (state)
          HUNT: begin
            if (byte_data == SYNC_BYTE)
              state <= GET_ADDR;
          end
          GET_ADDR: begin
            if (byte_data[7:4] == 4'h0) begin
              addr_q <= byte_data[3:0];
              state  <= GET_DATA;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_ADDR;
              state     <= HUNT;
            end
          end
          GET_DATA: begin
            data_q <= byte_data;
            state  <= GET_CHK;
          end
          GET_CHK: begin
            if (byte_data == frame_chk(addr_q, data_q)) begin
              reg_we    <= 1'b1;
              frame_ok  <= 1'b1;
              reg_addr  <= addr_q;
              reg_wdata <= data_q;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CHK;
            end
            state <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end else if (tmo_hit) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TMO;
        tmo_cnt   <= 8'd0;
        state     <= HUNT;
      end else if (baud_tick && (state != HUNT)) begin
        tmo_cnt <= sat_inc(tmo_cnt);
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed frames, timeout/reset corner cases, then random byte traffic
// compared against a queue-based frame model.
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_tick;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       reg_we;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0] fq[$];
  logic [1:0] m_err;
  logic [3:0] m_addr;
  logic [7:0] m_data;
  logic       exp_we, exp_ok, exp_err;

  uart_cmd_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_TICKS(8'd200)) dut (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .byte_valid(byte_valid),
    .byte_data(byte_data), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    m_err = 2'd0; m_addr = 4'd0; m_data = 8'd0;
    exp_we = 1'b0; exp_ok = 1'b0; exp_err = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    exp_we = 1'b0; exp_ok = 1'b0; exp_err = 1'b0;
    case (fq.size())
      0: if (b == 8'hA5) fq.push_back(b);
      1: begin
        if (b[7:4] != 4'h0) begin
          exp_err = 1'b1; m_err = 2'd2; fq.delete();
        end else fq.push_back(b);
      end
      2: fq.push_back(b);
      default: begin
        if (b == (fq[0] ^ fq[1] ^ fq[2])) begin
          exp_we = 1'b1; exp_ok = 1'b1;
          m_addr = fq[1][3:0]; m_data = fq[2];
        end else begin
          exp_err = 1'b1; m_err = 2'd1;
        end
        fq.delete();
      end
    endcase
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_we"},    reg_we,    exp_we);
    chk({tag, "_ok"},    frame_ok,  exp_ok);
    chk({tag, "_err"},   frame_err, exp_err);
    chk({tag, "_code"},  err_code,  m_err);
    chk({tag, "_addr"},  reg_addr,  m_addr);
    chk({tag, "_wdata"}, reg_wdata, m_data);
    chk({tag, "_busy"},  busy,      fq.size() != 0);
  endtask

  // Called #1 after an edge; leaves #1 after the edge that captured the byte.
  task automatic send_chk(input logic [7:0] b, input logic tick, input string tag);
    model_byte(b);
    byte_valid = 1'b1; byte_data = b; baud_tick = tick;
    @(posedge clk); #1;
    byte_valid = 1'b0; baud_tick = 1'b0;
    check_outs(tag);
  endtask

  task automatic idle(input int n, input bit rnd);
    exp_we = 1'b0; exp_ok = 1'b0; exp_err = 1'b0;
    repeat (n) begin
      baud_tick = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      baud_tick = 1'b0;
      check_outs("idle");
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      baud_tick = 1'b1;
      @(posedge clk); #1;
      baud_tick = 1'b0;
    end
  endtask

  initial begin
    bit seen;
    int kind;
    logic [7:0] a, d, c;
    rst_n = 1'b0; baud_tick = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    model_reset();
    #3;
    check_outs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2, 0);

    // Good frame, bad checksum, junk then bad address, SYNC value as data
    send_chk(8'hA5, 0, "ok_s"); send_chk(8'h03, 0, "ok_a");
    send_chk(8'h5C, 0, "ok_d"); send_chk(8'hFA, 0, "ok_c");
    idle(1, 0);
    send_chk(8'hA5, 0, "bc_s"); send_chk(8'h03, 0, "bc_a");
    send_chk(8'h5C, 0, "bc_d"); send_chk(8'h00, 0, "bc_c");
    send_chk(8'h11, 0, "ba_j1"); send_chk(8'h22, 0, "ba_j2");
    send_chk(8'hA5, 0, "ba_s"); send_chk(8'h1F, 0, "ba_a");
    send_chk(8'hA5, 0, "sd_s"); send_chk(8'h01, 1, "sd_a");
    send_chk(8'hA5, 1, "sd_d"); send_chk(8'h01, 0, "sd_c");

    // Timeout: 199 ticks tolerated, the 200th expires the frame
    send_chk(8'hA5, 0, "to_s"); send_chk(8'h03, 0, "to_a");
    ticks(199);
    idle(3, 0);
    ticks(1);
    fq.delete(); m_err = 2'd3;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (frame_err === 1'b1) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("tmo_pulse", seen, 1'b1);
    chk("tmo_code", err_code, 2'd3);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_we", reg_we, 1'b0);
    idle(1, 0);
    send_chk(8'hA5, 0, "pt_s"); send_chk(8'h03, 0, "pt_a");
    send_chk(8'h5C, 0, "pt_d"); send_chk(8'hFA, 0, "pt_c");

    // Byte arriving on the very clock the timeout would expire wins
    send_chk(8'hA5, 0, "co_s"); send_chk(8'h07, 0, "co_a");
    ticks(200);
    send_chk(8'h3C, 1, "co_d"); send_chk(8'hA5 ^ 8'h07 ^ 8'h3C, 0, "co_c");

    // Reset mid-frame discards it without strobes
    send_chk(8'hA5, 0, "rs_s"); send_chk(8'h03, 0, "rs_a");
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outs("rs_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_chk(8'h5C, 0, "rs_d"); send_chk(8'hFA, 0, "rs_c");
    idle(2, 0);

    // Random traffic: valid, bad-checksum, bad-address frames and junk bytes
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 3);
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom_range(0, 255));
      c = 8'hA5 ^ a ^ d;
      case (kind)
        0: begin
          send_chk(8'hA5, 1'($urandom_range(0, 1)), "rnd_s");
          send_chk(a, 1'($urandom_range(0, 1)), "rnd_a");
          send_chk(d, 1'($urandom_range(0, 1)), "rnd_d");
          send_chk(c, 1'($urandom_range(0, 1)), "rnd_c");
        end
        1: begin
          send_chk(8'hA5, 1'($urandom_range(0, 1)), "rnd_s");
          send_chk(a, 1'($urandom_range(0, 1)), "rnd_a");
          send_chk(d, 1'($urandom_range(0, 1)), "rnd_d");
          send_chk(c ^ 8'(1 << $urandom_range(0, 7)), 1'($urandom_range(0, 1)), "rnd_c");
        end
        2: begin
          send_chk(8'hA5, 1'($urandom_range(0, 1)), "rnd_s");
          send_chk(8'($urandom_range(16, 255)), 1'($urandom_range(0, 1)), "rnd_a");
        end
        default: send_chk(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "rnd_j");
      endcase
      idle($urandom_range(0, 2), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
